// File: rtl/grizzly_pkg.sv
// Shared fetch-path types and widths.
package grizzly_pkg;

   localparam int unsigned ADDR_W = 16;
   localparam int unsigned DATA_W = 16;
   localparam logic [ADDR_W-1:0] RESET_VECTOR = 16'h0000;

   typedef struct packed {
      logic [ADDR_W-1:0] pc;
      logic [DATA_W-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO of fetched {pc, instr} entries; flush wins over push/pop.
module fetch_queue
   import grizzly_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      push,
   input  fetch_entry_t              wdata,
   input  logic                      pop,
   input  logic                      flush,
   output fetch_entry_t              head_c,
   output logic                      full_c,
   output logic                      empty_c,
   output logic [$clog2(DEPTH):0]    count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   fetch_entry_t           mem [DEPTH];
   logic [PTR_W-1:0]       rd_ptr;
   logic [PTR_W-1:0]       wr_ptr;
   logic [CNT_W-1:0]       cnt;
   logic                   do_push;
   logic                   do_pop;

   assign full_c  = (cnt == CNT_W'(DEPTH));
   assign empty_c = (cnt == '0);
   assign head_c  = mem[rd_ptr];
   assign count   = cnt;

   // A push into a full queue is only legal alongside a pop (slot freed this edge).
   assign do_pop  = pop & ~empty_c;
   assign do_push = push & (~full_c | do_pop);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         cnt    <= '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem[i] <= '0;
         end
      end else if (flush) begin
         rd_ptr <= wr_ptr;
         cnt    <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= wdata;
            wr_ptr      <= wr_ptr + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         cnt <= cnt + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC register, ROM address, fetch queue and decode handshake.
module fetch_unit #(
   parameter int unsigned      ADDR_W      = grizzly_pkg::ADDR_W,
   parameter int unsigned      DATA_W      = grizzly_pkg::DATA_W,
   parameter logic [ADDR_W-1:0] RESET_PC   = grizzly_pkg::RESET_VECTOR,
   parameter int unsigned      QUEUE_DEPTH = 2
) (
   input  logic                           Clk,
   input  logic                           ResetN,
   output logic [ADDR_W-1:0]              RomAddress,
   input  logic [DATA_W-1:0]              RomData,
   output logic [DATA_W-1:0]              Instr,
   output logic [ADDR_W-1:0]              InstrPc,
   output logic                           InstrValid,
   input  logic                           InstrReady,
   input  logic                           Redirect,
   input  logic [ADDR_W-1:0]              RedirectPc,
   input  logic                           Halt,
   output logic [$clog2(QUEUE_DEPTH):0]   QueueCount
);

   import grizzly_pkg::fetch_entry_t;

   logic [ADDR_W-1:0] pc;
   fetch_entry_t      wr_entry;
   fetch_entry_t      head;
   logic              full;
   logic              empty;
   logic              push;
   logic              pop;

   assign RomAddress = pc;
   assign InstrValid = ~empty;
   assign Instr      = head.instr;
   assign InstrPc    = head.pc;

   assign pop      = InstrValid & InstrReady;
   assign push     = ~Halt & ~Redirect & (~full | pop);
   assign wr_entry = '{pc: pc, instr: RomData};

   // Reset beats redirect; redirect beats halt and any fetch.
   always_ff @(posedge Clk) begin
      if (!ResetN) begin
         pc <= RESET_PC;
      end else if (Redirect) begin
         pc <= RedirectPc;
      end else if (push) begin
         pc <= pc + ADDR_W'(1);
      end
   end

   fetch_queue #(
      .DEPTH (QUEUE_DEPTH)
   ) u_queue (
      .clk     (Clk),
      .rst_n   (ResetN),
      .push    (push),
      .wdata   (wr_entry),
      .pop     (pop),
      .flush   (Redirect),
      .head_c  (head),
      .full_c  (full),
      .empty_c (empty),
      .count   (QueueCount)
   );

endmodule
